// File: rtl/vadd_pkg.sv
// Shared types and helpers for the vector-add sequencer.
//   VEC_W / LANES / FP_W : adder row geometry (16 lanes of fp32)
//   state_e              : sequencer states
//   lane_get             : extract one fp32 lane from a row
package vadd_pkg;

  localparam int unsigned VEC_W = 512;
  localparam int unsigned LANES = 16;
  localparam int unsigned FP_W  = 32;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Return lane idx (lane 0 in the LSBs) of a packed row.
  function automatic logic [FP_W-1:0] lane_get(input logic [VEC_W-1:0] vec,
                                               input int unsigned      idx);
    return vec[idx*FP_W +: FP_W];
  endfunction

endpackage

// File: rtl/vadd_delay_line.sv
// Valid/data alignment pipeline for late-arriving read data.
// i_valid is delayed DEPTH cycles; i_data is sampled once, on the cycle the
// valid has travelled DEPTH-1 stages (i.e. when a read issued DEPTH-1 cycles
// earlier returns its data), so o_valid and o_data leave together.
// DEPTH must be >= 2.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_valid/i_data  strobe and its late data
//   o_valid/o_data  aligned, registered outputs (data zero when not valid)
module vadd_delay_line #(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DEPTH-1:0]  r_vld;
  logic [DATA_W-1:0] r_data;

  // Valid shift chain plus final data capture stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_data <= '0;
    end else begin
      r_vld  <= {r_vld[DEPTH-2:0], i_valid};
      r_data <= r_vld[DEPTH-2] ? i_data : '0;
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_data  = r_data;

endmodule

// File: rtl/vector_add_seq.sv
// Sequencer around the 16-lane fp32 vector adder: streams operand rows from
// two source buffers into the adder and writes results to a destination
// buffer, pulsing done after the last write.
// Optional macro VADD_SEQ_RELU_EN: negative result lanes are written as zero.
// Ports:
//   clk, rst                      clock, async active-high reset
//   instr_*                       instruction handshake and fields
//   done, err                     completion pulse, sticky stray-result flag
//   buf1_*/buf2_*                 source buffer read ports
//   add_vector_*, add_input_valid adder operands
//   add_output_valid, add_result  adder results
//   out_wr_*                      destination buffer write port
module vector_add_seq
  import vadd_pkg::*;
#(
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned LEN_W           = 13,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned ADD_LATENCY_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [ADDR_W-1:0] instr_src1_addr,
  input  logic [ADDR_W-1:0] instr_src2_addr,
  input  logic [ADDR_W-1:0] instr_dst_addr,
  input  logic [LEN_W-1:0]  instr_len,
  output logic              done,
  output logic              err,
  output logic              buf1_rd_en,
  output logic              buf2_rd_en,
  output logic [ADDR_W-1:0] buf1_rd_addr,
  output logic [ADDR_W-1:0] buf2_rd_addr,
  input  logic [VEC_W-1:0]  buf1_rd_data,
  input  logic [VEC_W-1:0]  buf2_rd_data,
  output logic [VEC_W-1:0]  add_vector_1,
  output logic [VEC_W-1:0]  add_vector_2,
  output logic              add_input_valid,
  input  logic              add_output_valid,
  input  logic [VEC_W-1:0]  add_result,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [VEC_W-1:0]  out_wr_data
);

  localparam int unsigned FLUSH_W = $clog2(ADD_LATENCY_MAX) + 1;

  state_e              r_state, w_state_nxt;
  logic [FLUSH_W-1:0]  r_flush_cnt;
  logic [ADDR_W-1:0]   r_src1, r_src2, r_dst;
  logic [LEN_W-1:0]    r_len, r_issue_cnt, r_wr_cnt;
  logic [LEN_W:0]      r_outst;
  logic                r_instr_ready, r_done, r_err;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr1, r_rd_addr2;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [VEC_W-1:0]    r_wr_data;

  logic                w_rd_en_nxt, w_done_nxt, w_load;
  logic [ADDR_W-1:0]   w_rd_addr1_nxt, w_rd_addr2_nxt;
  logic [LEN_W-1:0]    w_issue_cnt_nxt;
  logic                w_add_valid;
  logic [2*VEC_W-1:0]  w_add_data;
  logic                w_res_ok, w_stray;
  logic [VEC_W-1:0]    w_res_mod;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FLUSH;
    else     r_state <= w_state_nxt;
  end

  // Next state plus next read-issue controls (registered below).
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_en_nxt     = 1'b0;
    w_rd_addr1_nxt  = r_rd_addr1;
    w_rd_addr2_nxt  = r_rd_addr2;
    w_issue_cnt_nxt = r_issue_cnt;
    w_done_nxt      = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      FLUSH: begin
        if (r_flush_cnt == FLUSH_W'(ADD_LATENCY_MAX - 1)) w_state_nxt = IDLE;
      end
      IDLE: begin
        if (instr_valid && r_instr_ready) begin
          if (instr_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_load          = 1'b1;
            w_state_nxt     = ISSUE;
            w_rd_en_nxt     = 1'b1;
            w_rd_addr1_nxt  = instr_src1_addr;
            w_rd_addr2_nxt  = instr_src2_addr;
            w_issue_cnt_nxt = '0;
          end
        end
      end
      ISSUE: begin
        // r_issue_cnt is the row whose read is on the bus this cycle.
        if (r_issue_cnt == r_len - LEN_W'(1)) begin
          w_state_nxt = DRAIN;
        end else begin
          w_rd_en_nxt     = 1'b1;
          w_issue_cnt_nxt = r_issue_cnt + LEN_W'(1);
          w_rd_addr1_nxt  = r_src1 + ADDR_W'(w_issue_cnt_nxt);
          w_rd_addr2_nxt  = r_src2 + ADDR_W'(w_issue_cnt_nxt);
        end
      end
      DRAIN: begin
        if (r_wr_cnt == r_len) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = FLUSH;
    endcase
  end

  // Results are only legal outside FLUSH and with an add in flight.
  assign w_res_ok = add_output_valid && (r_state != FLUSH) && (r_outst != '0);
  assign w_stray  = add_output_valid && (r_state != FLUSH) && (r_outst == '0);

  // Result lane post-processing in the write register stage.
`ifdef VADD_SEQ_RELU_EN
  logic [FP_W-1:0] w_lane;
  always_comb begin
    w_res_mod = add_result;
    w_lane    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane = lane_get(add_result, i);
      if (w_lane[FP_W-1]) w_res_mod[i*FP_W +: FP_W] = '0;
    end
  end
`else
  always_comb begin
    w_res_mod = add_result;
  end
`endif

  // Control, issue and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt   <= '0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_dst         <= '0;
      r_len         <= '0;
      r_issue_cnt   <= '0;
      r_wr_cnt      <= '0;
      r_outst       <= '0;
      r_instr_ready <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rd_en       <= 1'b0;
      r_rd_addr1    <= '0;
      r_rd_addr2    <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
    end else begin
      r_flush_cnt   <= (r_state == FLUSH) ? r_flush_cnt + FLUSH_W'(1) : '0;
      r_instr_ready <= (w_state_nxt == IDLE);
      r_done        <= w_done_nxt;
      r_err         <= r_err | w_stray;
      r_rd_en       <= w_rd_en_nxt;
      r_rd_addr1    <= w_rd_addr1_nxt;
      r_rd_addr2    <= w_rd_addr2_nxt;
      r_issue_cnt   <= w_issue_cnt_nxt;
      if (w_load) begin
        r_src1   <= instr_src1_addr;
        r_src2   <= instr_src2_addr;
        r_dst    <= instr_dst_addr;
        r_len    <= instr_len;
        r_wr_cnt <= '0;
      end else if (w_res_ok) begin
        r_wr_cnt <= r_wr_cnt + LEN_W'(1);
      end
      r_wr_en   <= w_res_ok;
      r_wr_data <= w_res_ok ? w_res_mod : '0;
      if (w_res_ok) r_wr_addr <= r_dst + ADDR_W'(r_wr_cnt);
      // Adds in flight; simultaneous issue and return cancel out.
      case ({w_add_valid, w_res_ok})
        2'b10:   r_outst <= r_outst + (LEN_W+1)'(1);
        2'b01:   r_outst <= r_outst - (LEN_W+1)'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Align read strobe with returning buffer data, then register as operands.
  vadd_delay_line #(
    .DEPTH  (RD_LATENCY + 1),
    .DATA_W (2 * VEC_W)
  ) u_rd_align (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_rd_en),
    .i_data  ({buf1_rd_data, buf2_rd_data}),
    .o_valid (w_add_valid),
    .o_data  (w_add_data)
  );

  assign instr_ready     = r_instr_ready;
  assign done            = r_done;
  assign err             = r_err;
  assign buf1_rd_en      = r_rd_en;
  assign buf2_rd_en      = r_rd_en;
  assign buf1_rd_addr    = r_rd_addr1;
  assign buf2_rd_addr    = r_rd_addr2;
  assign add_input_valid = w_add_valid;
  assign add_vector_1    = w_add_data[2*VEC_W-1:VEC_W];
  assign add_vector_2    = w_add_data[VEC_W-1:0];
  assign out_wr_en       = r_wr_en;
  assign out_wr_addr     = r_wr_addr;
  assign out_wr_data     = r_wr_data;

endmodule

// File: tb/tb_vector_add_seq.sv
module tb_vector_add_seq;

  localparam int unsigned AW      = 12;
  localparam int unsigned LW      = 13;
  localparam int unsigned VW      = 512;
  localparam int unsigned ADD_LAT = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] instr_src1_addr, instr_src2_addr, instr_dst_addr;
  logic [LW-1:0] instr_len;
  logic          done, err;
  logic          buf1_rd_en, buf2_rd_en;
  logic [AW-1:0] buf1_rd_addr, buf2_rd_addr;
  logic [VW-1:0] buf1_rd_data, buf2_rd_data;
  logic [VW-1:0] add_vector_1, add_vector_2;
  logic          add_input_valid, add_output_valid;
  logic [VW-1:0] add_result;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [VW-1:0] out_wr_data;

  always #5 clk = ~clk;

  vector_add_seq dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_src1_addr  (instr_src1_addr),
    .instr_src2_addr  (instr_src2_addr),
    .instr_dst_addr   (instr_dst_addr),
    .instr_len        (instr_len),
    .done             (done),
    .err              (err),
    .buf1_rd_en       (buf1_rd_en),
    .buf2_rd_en       (buf2_rd_en),
    .buf1_rd_addr     (buf1_rd_addr),
    .buf2_rd_addr     (buf2_rd_addr),
    .buf1_rd_data     (buf1_rd_data),
    .buf2_rd_data     (buf2_rd_data),
    .add_vector_1     (add_vector_1),
    .add_vector_2     (add_vector_2),
    .add_input_valid  (add_input_valid),
    .add_output_valid (add_output_valid),
    .add_result       (add_result),
    .out_wr_en        (out_wr_en),
    .out_wr_addr      (out_wr_addr),
    .out_wr_data      (out_wr_data)
  );

  // ---------------- buffer model: read latency 2 ----------------
  logic [VW-1:0] mem1 [4096];
  logic [VW-1:0] mem2 [4096];
  logic [VW-1:0] rd1_s1, rd1_s2, rd2_s1, rd2_s2;
  always @(posedge clk) begin
    rd1_s1 <= mem1[buf1_rd_addr];
    rd2_s1 <= mem2[buf2_rd_addr];
    rd1_s2 <= rd1_s1;
    rd2_s2 <= rd2_s1;
  end
  assign buf1_rd_data = rd1_s2;
  assign buf2_rd_data = rd2_s2;

  // ---------------- fp32 adder model: latency 11, not reset ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [VW-1:0] vadd(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s[i*32 +: 32] = r2f(f2r(a[i*32 +: 32]) + f2r(b[i*32 +: 32]));
    return s;
  endfunction

  logic [ADD_LAT-1:0] apv = '0;
  logic [VW-1:0]      apd [ADD_LAT];
  always @(posedge clk) begin
    apv <= {apv[ADD_LAT-2:0], add_input_valid};
    apd[0] <= vadd(add_vector_1, add_vector_2);
    for (int i = 1; i < int'(ADD_LAT); i++) apd[i] <= apd[i-1];
  end

  logic          inj_v = 1'b0;
  logic [VW-1:0] inj_d = '0;
  assign add_output_valid = apv[ADD_LAT-1] | inj_v;
  assign add_result       = inj_v ? inj_d : apd[ADD_LAT-1];

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [VW-1:0] d;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_wr = 0, n_done = 0, n_rd = 0;
  int last_wr_cyc = -1, done_cyc = -1;
  logic [AW-1:0] rd1_log[$], rd2_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_wr_en) begin
        exp_t e;
        n_wr++;
        last_wr_cyc = cyc;
        n_chk++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL wr_unexpected: observed write addr %0h, expected no write", out_wr_addr);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_chk++;
          assert (out_wr_addr === e.a) else begin
            n_fail++;
            $error("FAIL wr_addr: observed %0h expected %0h", out_wr_addr, e.a);
          end
          n_chk++;
          assert (out_wr_data === e.d) else begin
            n_fail++;
            $error("FAIL wr_data@%0h: observed %0h expected %0h", e.a, out_wr_data, e.d);
          end
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (buf1_rd_en) begin
        n_rd++;
        rd1_log.push_back(buf1_rd_addr);
      end
      if (buf2_rd_en) rd2_log.push_back(buf2_rd_addr);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] splat(input logic [31:0] v);
    return {16{v}};
  endfunction

  task automatic send(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input logic [AW-1:0] d, input logic [LW-1:0] len);
    instr_src1_addr = s1;
    instr_src2_addr = s2;
    instr_dst_addr  = d;
    instr_len       = len;
    instr_valid     = 1'b1;
    tick(1);
    instr_valid     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int k;
    k = 0;
    while (n_done == start && k < 400) begin
      tick(1);
      k++;
    end
    chki(tag, n_done - start, 1);
  endtask

  task automatic flush_check(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk(tag, VW'(instr_ready), VW'(k == 16));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wr0, rd0, dn0;
    logic [VW-1:0] row;
    logic [VW-1:0] res_row;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_src1_addr = '0;
    instr_src2_addr = '0;
    instr_dst_addr = '0;
    instr_len = '0;
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = splat(32'h3F800000);
      mem2[i] = splat(32'h40000000);
    end
    tick(3);

    // reset state
    chk("rst_ready", VW'(instr_ready), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    chk("rst_err", VW'(err), VW'(0));
    chk("rst_rd_en", VW'(buf1_rd_en), VW'(0));
    chk("rst_wr_en", VW'(out_wr_en), VW'(0));
    chk("rst_add_valid", VW'(add_input_valid), VW'(0));

    // flush window with a stray result on the 5th cycle
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        inj_v = 1'b1;
        inj_d = splat(32'h12345678);
      end
      tick(1);
      inj_v = 1'b0;
      chk("flush_ready", VW'(instr_ready), VW'(k == 16));
    end
    chki("flush_no_write", n_wr, 0);
    chk("flush_err", VW'(err), VW'(0));

    // basic add: 1.0 + 2.0 = 3.0 per lane
    for (int i = 0; i < 4; i++) sb.push_back('{a: AW'(12'h200 + i), d: splat(32'h40400000)});
    dn0 = n_done;
    send(12'h000, 12'h100, 12'h200, 13'd4);
    wait_done("add4_done", dn0);
    chki("add4_writes", n_wr, 4);
    chki("add4_done_after_wr", done_cyc, last_wr_cyc + 1);
    chki("add4_sb_empty", sb.size(), 0);
    chk("add4_err", VW'(err), VW'(0));

    // zero length: done next cycle, no traffic
    tick(2);
    wr0 = n_wr;
    rd0 = n_rd;
    chk("len0_ready", VW'(instr_ready), VW'(1));
    send(12'h010, 12'h020, 12'h030, 13'd0);
    chk("len0_done", VW'(done), VW'(1));
    tick(1);
    chk("len0_done_pulse", VW'(done), VW'(0));
    tick(30);
    chki("len0_no_rd", n_rd, rd0);
    chki("len0_no_wr", n_wr, wr0);

    // address wrap on sources
    rd1_log.delete();
    rd2_log.delete();
    for (int i = 0; i < 4; i++) sb.push_back('{a: AW'(12'h300 + i), d: splat(32'h40400000)});
    dn0 = n_done;
    send(12'hFFE, 12'h0F0, 12'h300, 13'd4);
    wait_done("wrap_done", dn0);
    chki("wrap_rd_count", rd1_log.size(), 4);
    if (rd1_log.size() == 4 && rd2_log.size() == 4) begin
      chk("wrap_rd1_0", VW'(rd1_log[0]), VW'(12'hFFE));
      chk("wrap_rd1_1", VW'(rd1_log[1]), VW'(12'hFFF));
      chk("wrap_rd1_2", VW'(rd1_log[2]), VW'(12'h000));
      chk("wrap_rd1_3", VW'(rd1_log[3]), VW'(12'h001));
      chk("wrap_rd2_0", VW'(rd2_log[0]), VW'(12'h0F0));
      chk("wrap_rd2_3", VW'(rd2_log[3]), VW'(12'h0F3));
    end

    // stray result while idle sets sticky err
    tick(2);
    wr0 = n_wr;
    inj_v = 1'b1;
    inj_d = splat(32'hDEADBEEF);
    tick(1);
    inj_v = 1'b0;
    chk("stray_err", VW'(err), VW'(1));
    tick(5);
    chk("stray_err_sticky", VW'(err), VW'(1));
    chki("stray_no_write", n_wr, wr0);

    // reset in the middle of a long instruction
    for (int i = 0; i < 100; i++) sb.push_back('{a: AW'(12'h600 + i), d: splat(32'h40400000)});
    send(12'h400, 12'h500, 12'h600, 13'd100);
    tick(24);
    chk("mid_rd_en", VW'(buf1_rd_en), VW'(1));
    #3 rst = 1'b1;
    #1;
    chk("arst_rd_en", VW'(buf1_rd_en), VW'(0));
    chk("arst_wr_en", VW'(out_wr_en), VW'(0));
    chk("arst_add_valid", VW'(add_input_valid), VW'(0));
    chk("arst_vec1", add_vector_1, '0);
    chk("arst_err", VW'(err), VW'(0));
    chk("arst_ready", VW'(instr_ready), VW'(0));
    sb.delete();
    wr0 = n_wr;
    dn0 = n_done;
    tick(2);
    rst = 1'b0;
    flush_check("reflush_ready");
    chki("reflush_no_write", n_wr, wr0);
    chki("reflush_no_done", n_done, dn0);
    chk("reflush_err", VW'(err), VW'(0));

    // post-reset instruction with a negative lane and destination wrap
    for (int i = 0; i < 3; i++) begin
      row = splat(32'h40800000);
      if (i == 1) row[31:0] = 32'hC0400000;
      mem1[12'h010 + i] = row;
      row = splat(32'h3F000000);
      if (i == 1) row[31:0] = 32'h40000000;
      mem2[12'h020 + i] = row;
      res_row = splat(32'h40900000);
`ifdef VADD_SEQ_RELU_EN
      if (i == 1) res_row[31:0] = 32'h00000000;
`else
      if (i == 1) res_row[31:0] = 32'hBF800000;
`endif
      sb.push_back('{a: AW'(12'hFFF + i), d: res_row});
    end
    wr0 = n_wr;
    dn0 = n_done;
    send(12'h010, 12'h020, 12'hFFF, 13'd3);
    wait_done("final_done", dn0);
    chki("final_writes", n_wr - wr0, 3);
    chki("final_done_after_wr", done_cyc, last_wr_cyc + 1);
    chki("final_sb_empty", sb.size(), 0);
    chk("final_err", VW'(err), VW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
